// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller: arbitrates the MEM-stage pipeline port and a DMA/loader port
// onto a single fixed-latency Data_Memory, with a burst limit so DMA cannot starve.
module dmem_access_ctrl #(
  parameter int LATENCY   = 2,
  parameter int MAX_BURST = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic [31:0] p_rdata,
  output logic        p_done,
  output logic        stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic        mem_write_En,
  output logic        mem_read_En,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state
);

  // Request/done protocol: a requester raises *_req with stable we/addr/wdata and holds them
  // until its *_done pulse (one cycle); the access completes even if req drops early.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LOAD  = 4'(LATENCY - 1);
  localparam logic [2:0] BURST_MAX = 3'(MAX_BURST);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [2:0]  burst;
  logic        owner_dma;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        grant;
  logic        grant_dma;

  assign grant     = (state == IDLE) && (p_req || d_req);
  // DMA only overrides a pending pipeline request once the pipeline has used its burst.
  assign grant_dma = d_req && (!p_req || (burst == BURST_MAX));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (p_req || d_req) state_nxt = BUSY;
      BUSY:    if (cnt == 4'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 4'd0;
      burst     <= 3'd0;
      owner_dma <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      p_rdata   <= 32'd0;
      d_rdata   <= 32'd0;
    end else if (grant) begin
      owner_dma <= grant_dma;
      lat_we    <= grant_dma ? d_we    : p_we;
      lat_addr  <= grant_dma ? d_addr  : p_addr;
      lat_wdata <= grant_dma ? d_wdata : p_wdata;
      cnt       <= CNT_LOAD;
      if (grant_dma || !d_req)   burst <= 3'd0;
      else if (burst != BURST_MAX) burst <= burst + 3'd1;
    end else if (state == BUSY) begin
      if (cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end else if (!lat_we) begin
        if (owner_dma) d_rdata <= mem_rdata;
        else           p_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_write_En = 1'b0;
    mem_read_En  = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;
    p_done       = 1'b0;
    d_done       = 1'b0;
    if (state == BUSY) begin
      mem_write_En = lat_we;
      mem_read_En  = !lat_we;
      mem_addr     = lat_addr;
      mem_wdata    = lat_wdata;
    end
    if (state == DONE) begin
      p_done = !owner_dma;
      d_done = owner_dma;
    end
  end

  assign stall     = p_req & ~p_done;
  assign dbg_state = state;

endmodule

// File: doc/dmem_access_ctrl.md
DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 SHALL have parameter LATENCY, default 2, giving data-memory access cycles (legal 1..15).
REQ-002 SHALL have parameter MAX_BURST, default 3, giving consecutive pipeline grants allowed while DMA waits (legal 1..7).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have ports p_req/p_we  input  1/1  MEM-stage access request / 1=write, 0=read.
REQ-006 SHALL have ports p_addr/p_wdata  input  32/32  MEM-stage address / write data.
REQ-007 SHALL have ports p_rdata  output  32  pipeline read data; p_done  output  1  one-cycle completion pulse.
REQ-008 SHALL have port stall  output  1  freeze request to IF/ID/EX/MEM pipeline registers.
REQ-009 SHALL have ports d_req/d_we  input  1/1  DMA/loader request / write select.
REQ-010 SHALL have ports d_addr/d_wdata  input  32/32  DMA address / write data.
REQ-011 SHALL have ports d_rdata  output  32; d_done  output  1  DMA read data / completion pulse.
REQ-012 SHALL have ports mem_write_En/mem_read_En  output  1/1  Data_Memory enables.
REQ-013 SHALL have ports mem_addr/mem_wdata  output  32/32; mem_rdata  input  32  Data_Memory address, write data, read data.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; state, owner, counter, captured address/data all registered.
REQ-015 In IDLE, if any request high at a rising edge, SHALL grant one requester, latch its we/addr/wdata, load cnt=LATENCY-1, go BUSY; else stay IDLE.
REQ-016 Arbitration SHALL favour p_req, except when d_req is high and burst counter == MAX_BURST, then DMA wins.
REQ-017 Burst counter SHALL increment on each pipeline grant made while d_req high, clear on DMA grant or on any grant made with d_req low, saturate at MAX_BURST.
REQ-018 In BUSY, mem_addr/mem_wdata SHALL drive latched values; mem_write_En = latched we; mem_read_En = !latched we; both 0 in IDLE and DONE.
REQ-019 In BUSY, cnt SHALL decrement each cycle; at cnt==0, the next edge SHALL capture mem_rdata into owner's rdata register (reads only) and go DONE.
REQ-020 In DONE, owner's done (p_done or d_done) SHALL be 1 for exactly that cycle, then IDLE; no new grant in DONE.
REQ-021 Latency: request high in IDLE cycle 0 -> done high in cycle LATENCY+1; back-to-back accesses therefore every LATENCY+2 cycles.
REQ-022 p_rdata/d_rdata SHALL hold last captured value until next read completion for that requester; writes SHALL not change them.
REQ-023 stall SHALL equal p_req & !p_done (combinational), so a pipeline access never completes in the cycle it is issued.
REQ-024 Requesters SHALL hold req and operands stable until their done; a request deasserted mid-access SHALL still complete and pulse done.
REQ-025 Simultaneous p_req and d_req with burst counter < MAX_BURST SHALL grant pipeline; the losing request SHALL remain pending with no side effect.
REQ-026 LATENCY==1 SHALL give exactly one BUSY cycle.

Reset
REQ-027 On rst at rising edge: state=IDLE, cnt=0, burst counter=0, p_rdata=d_rdata=0, p_done=d_done=0, mem enables 0, mem_addr/mem_wdata=0.
REQ-028 rst during BUSY SHALL abort the access with no done pulse; a still-high p_req keeps stall=1 and is re-arbitrated from IDLE after reset releases.

Verification
REQ-029 Pipeline read: memory[0x10]=0xDEADBEEF, LATENCY=2, p_req=1,p_we=0,p_addr=0x10 -> mem_read_En high cycles 1-2, p_done cycle 3, p_rdata=0xDEADBEEF, stall 1 cycles 0-2.
REQ-030 Pipeline write then read: write 0x12345678 to 0x20, then read 0x20 -> p_rdata=0x12345678; mem_write_En high exactly LATENCY cycles.
REQ-031 Contention: p_req and d_req held high continuously, MAX_BURST=3 -> grant order P,P,P,D,P,P,P,D; d_done every 4th completion.
REQ-032 Simultaneous single requests with burst counter 0 -> pipeline served first, DMA done LATENCY+2 cycles after p_done.
REQ-033 rst asserted in second BUSY cycle of a DMA write -> no d_done, enables 0 next cycle, all outputs at REQ-027 values.
REQ-034 LATENCY=1 read -> p_done in cycle 2, mem_read_En high only in cycle 1.
